spi_3wire_peripheral: RTL

Responder side of the team's 3-wire (shared DIO) SPI link. It lets an FPGA design emulate a HT16D35A/TM1638-style peripheral, or act as a loopback target for verifying the 3-wire SPI controller.
- It oversamples the external `sck`, `cs_n` and `dio` pins in the system clock domain.
- It shifts in write bytes on `sck` rising edges and hands each completed byte to the user logic.
- When the first byte of a transaction matches the read command, it drives read bytes back on `sck` falling edges until chip select is released.

---
 rtl/spi_3wire_pkg.sv | 20 ++
 rtl/spi_pin_sync.sv | 33 +++
 rtl/spi_3wire_peripheral.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/spi_3wire_pkg.sv
// Shared types and constants for the 3-wire SPI controller and peripheral.
// Pin idle levels live here so both ends agree on what "quiet" looks like.
package spi_3wire_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RX,
        S_TX
    } periph_state_t;

    localparam logic SCK_IDLE = 1'b1;
    localparam logic CS_IDLE  = 1'b1;

    function automatic logic is_read_cmd(input logic [7:0] b,
                                         input logic [7:0] cmd,
                                         input logic [7:0] mask);
        return (b & mask) == (cmd & mask);
    endfunction

endpackage

// File: rtl/spi_pin_sync.sv
// Multi-flop synchronizer for one asynchronous pin, plus a history flop
// that turns level changes into single-cycle rise/fall strobes.
module spi_pin_sync #(
    parameter int unsigned STAGES = 2,
    parameter logic        IDLE   = 1'b1
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic pin_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;
    logic              hist_q;

    // Preset to the idle level so leaving reset never looks like an edge.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sync_q <= {STAGES{IDLE}};
            hist_q <= IDLE;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], pin_i};
            hist_q <= sync_q[STAGES-1];
        end
    end

    assign level_o = sync_q[STAGES-1];
    assign rise_o  = sync_q[STAGES-1] & ~hist_q;
    assign fall_o  = ~sync_q[STAGES-1] & hist_q;

endmodule

// File: rtl/spi_3wire_peripheral.sv
// Responder side of the shared-DIO SPI link: receives write bytes on sck
// rise and, after a matching read command, drives read bytes on sck fall.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   S_IDLE | deselected, DIO released, waiting for a cs_n fall
//   S_RX   | selected, shifting in write bytes on sck rise
//   S_TX   | read command seen, driving tx bits on sck fall
module spi_3wire_peripheral
    import spi_3wire_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [7:0]  READ_CMD    = 8'h42,
    parameter logic [7:0]  READ_MASK   = 8'hFF,
    parameter bit          LSB_FIRST   = 1'b0,
    parameter bit          OPEN_DRAIN  = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sck,
    input  logic       cs_n,
    input  logic       dio_i,
    output logic       dio_o,
    output logic       dio_e,
    output logic       selected,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_first,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_load,
    output logic       tx_underrun,
    output logic       frame_error
);

    localparam int unsigned     SW          = $clog2(SYNC_STAGES + 2);
    localparam logic [SW-1:0]   SETTLE_DONE = SW'(SYNC_STAGES + 1);

    logic sck_rise, sck_fall, cs_rise, cs_fall, dio_s;
    logic sck_level_unused, cs_level_unused, dio_rise_unused, dio_fall_unused;

    spi_pin_sync #(.STAGES(SYNC_STAGES), .IDLE(SCK_IDLE)) u_sync_sck (
        .clk_i(clk), .reset_i(reset), .pin_i(sck),
        .level_o(sck_level_unused), .rise_o(sck_rise), .fall_o(sck_fall)
    );

    spi_pin_sync #(.STAGES(SYNC_STAGES), .IDLE(CS_IDLE)) u_sync_cs (
        .clk_i(clk), .reset_i(reset), .pin_i(cs_n),
        .level_o(cs_level_unused), .rise_o(cs_rise), .fall_o(cs_fall)
    );

    spi_pin_sync #(.STAGES(SYNC_STAGES), .IDLE(1'b1)) u_sync_dio (
        .clk_i(clk), .reset_i(reset), .pin_i(dio_i),
        .level_o(dio_s), .rise_o(dio_rise_unused), .fall_o(dio_fall_unused)
    );

    periph_state_t  state_q;
    logic [2:0]     bit_cnt_q;
    logic [7:0]     shift_q;
    logic [7:0]     tx_shift_q;
    logic           first_q;
    logic [SW-1:0]  settle_q;
    logic           dio_o_q, dio_e_q, selected_q;
    logic [7:0]     rx_data_q;
    logic           rx_valid_q, rx_first_q, tx_load_q, tx_underrun_q, frame_error_q;

    logic [7:0] rx_next;
    logic [2:0] tx_idx;
    logic       tx_bit;
    logic       load_tx;

    always_comb begin
        rx_next = LSB_FIRST ? {dio_s, shift_q[7:1]} : {shift_q[6:0], dio_s};
        tx_idx  = LSB_FIRST ? bit_cnt_q : 3'd7 - bit_cnt_q;
        tx_bit  = tx_shift_q[tx_idx];
        load_tx = sck_rise && !cs_rise && (bit_cnt_q == 3'd7) &&
                  ((state_q == S_RX && first_q && is_read_cmd(rx_next, READ_CMD, READ_MASK)) ||
                   state_q == S_TX);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            bit_cnt_q     <= 3'd0;
            shift_q       <= 8'h00;
            tx_shift_q    <= 8'hFF;
            first_q       <= 1'b0;
            settle_q      <= '0;
            dio_o_q       <= 1'b0;
            dio_e_q       <= 1'b0;
            selected_q    <= 1'b0;
            rx_data_q     <= 8'h00;
            rx_valid_q    <= 1'b0;
            rx_first_q    <= 1'b0;
            tx_load_q     <= 1'b0;
            tx_underrun_q <= 1'b0;
            frame_error_q <= 1'b0;
        end else begin
            rx_valid_q    <= 1'b0;
            rx_first_q    <= 1'b0;
            tx_load_q     <= 1'b0;
            tx_underrun_q <= 1'b0;
            frame_error_q <= 1'b0;

            // A cs_n held low across reset flushes through the preset
            // synchronizer as a fall; it must not start a transaction.
            if (settle_q != SETTLE_DONE)
                settle_q <= settle_q + 1'b1;

            if (load_tx) begin
                if (tx_valid) begin
                    tx_shift_q <= tx_data;
                    tx_load_q  <= 1'b1;
                end else begin
                    tx_shift_q    <= 8'hFF;
                    tx_underrun_q <= 1'b1;
                end
            end

            if (cs_rise) begin
                state_q       <= S_IDLE;
                dio_e_q       <= 1'b0;
                selected_q    <= 1'b0;
                bit_cnt_q     <= 3'd0;
                first_q       <= 1'b0;
                frame_error_q <= (bit_cnt_q != 3'd0);
            end else begin
                unique case (state_q)
                    S_IDLE: begin
                        dio_e_q   <= 1'b0;
                        bit_cnt_q <= 3'd0;
                        if (cs_fall && settle_q == SETTLE_DONE) begin
                            state_q    <= S_RX;
                            selected_q <= 1'b1;
                            first_q    <= 1'b1;
                        end
                    end
                    S_RX: begin
                        if (sck_rise) begin
                            shift_q   <= rx_next;
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                            if (bit_cnt_q == 3'd7) begin
                                rx_data_q  <= rx_next;
                                rx_valid_q <= 1'b1;
                                rx_first_q <= first_q;
                                first_q    <= 1'b0;
                                if (load_tx)
                                    state_q <= S_TX;
                            end
                        end
                    end
                    S_TX: begin
                        if (sck_fall) begin
                            dio_e_q <= OPEN_DRAIN ? ~tx_bit : 1'b1;
                            dio_o_q <= OPEN_DRAIN ? 1'b0 : tx_bit;
                        end
                        if (sck_rise)
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign dio_o       = dio_o_q;
    assign dio_e       = dio_e_q;
    assign selected    = selected_q;
    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign rx_first    = rx_first_q;
    assign tx_load     = tx_load_q;
    assign tx_underrun = tx_underrun_q;
    assign frame_error = frame_error_q;

endmodule
